io_uart: RTL and testbench
==========================

IO_UART -- requirements
Module: io_uart

Interface
- REQ-001: Parameter CLK_PER_BIT, default 868, gives clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- REQ-002: Parameter FIFO_DEPTH, default 16, gives entries per FIFO; power of two, minimum 2.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: io_in_data  output  8  head byte of RX FIFO, to CPU.
- REQ-006: io_in_vld  output  1  RX FIFO non-empty.
- REQ-007: io_in_rdy  input  1  CPU accepts byte.
- REQ-008: io_out_data  input  8  byte from CPU for transmission.
- REQ-009: io_out_vld  input  1  CPU offers byte.
- REQ-010: io_out_rdy  output  1  TX FIFO not full.
- REQ-011: io_err  output  5  sticky error flags to CPU.
- REQ-012: uart_rxd  input  1  asynchronous serial input, idle high.
- REQ-013: uart_txd  output  1  serial output, idle high.

Function
- REQ-014: A transfer occurs on a rising edge where vld and rdy are both high; there is no other transfer condition.
- REQ-015: io_in_data shall be valid and stable whenever io_in_vld is high, changing only after a pop.
- REQ-016: Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- REQ-017: uart_rxd shall pass a 2-flop synchronizer before any use.
- REQ-018: RX FSM states: IDLE, START, DATA, STOP.
- REQ-019: IDLE->START on synchronized high-to-low transition.
- REQ-020: In START, sample at CLK_PER_BIT/2 cycles; high -> set io_err[2] (false start), return to IDLE; low -> DATA.
- REQ-021: In DATA, sample every CLK_PER_BIT cycles, 8 samples; then STOP.
- REQ-022: In STOP, sample after CLK_PER_BIT cycles, then return to IDLE; low stop bit -> set io_err[1] (framing), discard byte.
- REQ-023: On a valid stop bit, push the byte when the RX FIFO is not full or a CPU pop occurs on the same edge; otherwise drop the byte and set io_err[0] (overrun).
- REQ-024: io_in_vld shall rise on the edge following the push edge.
- REQ-025: TX FSM states: IDLE, START, DATA, STOP; uart_txd registered.
- REQ-026: In IDLE with TX FIFO non-empty, pop one byte and enter START, driving uart_txd low from that edge.
- REQ-027: Each of START, the 8 DATA bits and STOP lasts exactly CLK_PER_BIT cycles; STOP drives 1, then IDLE.
- REQ-028: Back-to-back frames: with data pending, next start bit begins one cycle after the STOP period ends (frame period 10*CLK_PER_BIT+1).
- REQ-029: io_out_rdy shall be low only when the TX FIFO holds FIFO_DEPTH entries; push and pop on the same edge leave the count unchanged.
- REQ-030: TX latency: io_out handshake at edge N -> uart_txd low after edge N+1 when TX is IDLE and the FIFO is empty.
- REQ-031: io_err[4:3] tie to 0; io_err[2:0] are set-only until reset; simultaneous set events OR together.
- REQ-032: FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
- REQ-033: While rst is high: both FSMs IDLE, FIFOs empty, counters 0, io_err=0, io_in_vld=0, io_out_rdy=0, uart_txd=1, synchronizer flops=1.
- REQ-034: io_out_rdy shall rise on the first edge after rst deasserts.
- REQ-035: rst asserted mid-frame aborts the frame immediately; uart_txd=1, no partial byte pushed, no error flagged.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4)
- REQ-036: CPU writes 0xA5 -> uart_txd low after N+1, then bits 1,0,1,0,0,1,0,1, then 1, each 4 cycles; 41-cycle frame period.
- REQ-037: Serial 0x3C driven on uart_rxd -> io_in_vld=1, io_in_data=0x3C; pop -> io_in_vld=0; io_err=0.
- REQ-038: Five RX frames with io_in_rdy=0 -> FIFO holds first four, io_err=5'b00001, fifth byte lost.
- REQ-039: RX frame 0x55 with stop bit 0 -> no push, io_err=5'b00010.
- REQ-040: 2-cycle low pulse on idle uart_rxd -> io_err=5'b00100, no push.
- REQ-041: Five CPU writes with TX busy -> io_out_rdy low at full; rst mid-frame -> uart_txd=1 at once, FIFO empty, io_err=0.

Source files
------------

// File: rtl/io_uart.sv
`timescale 1ns/1ps
// io_uart: 8N1 UART with valid/ready CPU FIFOs on both the RX and TX paths.
// io_err flags are sticky: [2] false start, [1] framing error, [0] RX overrun.

module io_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
endmodule

module io_uart #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [4:0] io_err,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    uart_state_t rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done, rx_false_start, rx_frame_err;
    logic        rx_push, rx_pop, rx_overrun, rx_empty, rx_full;

    uart_state_t tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_rdata;

    logic        rdy_en_q;
    logic [2:0]  err_q, err_d;

    assign io_in_vld  = ~rx_empty;
    assign rx_pop     = io_in_vld & io_in_rdy;
    assign rx_push    = rx_done & (~rx_full | rx_pop);
    assign rx_overrun = rx_done & rx_full & ~rx_pop;
    // Keeps io_out_rdy low through reset and rising on the first edge after it.
    assign io_out_rdy = rdy_en_q & ~tx_full;
    assign tx_push    = io_out_vld & io_out_rdy;
    assign uart_txd   = txd_q;
    assign io_err     = {2'b00, err_q};

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q + 16'd1;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_done        = 1'b0;
        rx_false_start = 1'b0;
        rx_frame_err   = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync2_q) rx_state_d = ST_START;
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    if (rx_sync2_q) begin
                        rx_false_start = 1'b1;
                        rx_state_d     = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sync2_q) rx_done      = 1'b1;
                    else            rx_frame_err = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_rdata;
                    txd_d      = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        err_d = err_q | {rx_false_start, rx_frame_err, rx_overrun};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rdy_en_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            rx_sync1_q <= uart_rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rdy_en_q   <= 1'b1;
            err_q      <= err_d;
        end
    end

    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (rx_shift_q),
        .rdata_o (io_in_data),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (io_out_data),
        .rdata_o (tx_rdata),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );
endmodule

// File: tb/tb_io_uart.sv
`timescale 1ns/1ps
// Self-checking bench for io_uart with CLK_PER_BIT=4, FIFO_DEPTH=4: directed
// table rows, hand-written corner sequences and randomized traffic against a queue model.

module tb_io_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_in_data;
    logic       io_in_vld;
    logic       io_in_rdy = 1'b0;
    logic [7:0] io_out_data = 8'h00;
    logic       io_out_vld = 1'b0;
    logic       io_out_rdy;
    logic [4:0] io_err;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    io_uart #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_in_data  (io_in_data),
        .io_in_vld   (io_in_vld),
        .io_in_rdy   (io_in_rdy),
        .io_out_data (io_out_data),
        .io_out_vld  (io_out_vld),
        .io_out_rdy  (io_out_rdy),
        .io_err      (io_err),
        .uart_rxd    (uart_rxd),
        .uart_txd    (uart_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line-level UART receiver watching uart_txd, sampling each bit in its middle.
    logic       mon_en = 1'b0;
    logic [7:0] mon_q[$];
    int         mon_t[$];
    int         mon_bad = 0;

    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_txd === 1'b0) begin
                mon_t.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                if (uart_txd !== 1'b0) mon_bad++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                if (uart_txd !== 1'b1) mon_bad++;
                mon_q.push_back(b);
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        io_in_rdy  = 1'b0;
        io_out_vld = 1'b0;
        uart_rxd   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_vld", io_in_vld, 0);
        check("rst_out_rdy", io_out_rdy, 0);
        check("rst_txd", uart_txd, 1);
        check("rst_err", io_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", io_out_rdy, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        io_out_data = d;
        io_out_vld  = 1'b1;
        while (!io_out_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wr_rdy", io_out_rdy, 1);
        @(posedge clk);
        #1 io_out_vld = 1'b0;
    endtask

    task automatic cpu_pop(output logic [7:0] d);
        @(negedge clk);
        d = io_in_data;
        io_in_rdy = 1'b1;
        @(posedge clk);
        #1 io_in_rdy = 1'b0;
    endtask

    task automatic wait_mon(input int n);
        int t;
        t = 0;
        while (mon_q.size() < n && t < n * 50 + 100) begin
            @(negedge clk);
            t++;
        end
        check("tx_mon_count", mon_q.size(), n);
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       stop;
        logic       exp_vld;
        logic [4:0] exp_err;
    } rx_vec_t;

    rx_vec_t rx_tab[6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] got;
        logic [7:0] b;
        logic [9:0] fr;
        logic [7:0] exp_q[$];
        logic [4:0] exp_err;
        logic       stop;
        int         lows;
        int         npop;

        rx_tab[0] = '{data: 8'h3C, stop: 1'b1, exp_vld: 1'b1, exp_err: 5'b00000};
        rx_tab[1] = '{data: 8'h55, stop: 1'b0, exp_vld: 1'b0, exp_err: 5'b00010};
        rx_tab[2] = '{data: 8'hA5, stop: 1'b1, exp_vld: 1'b1, exp_err: 5'b00000};
        rx_tab[3] = '{data: 8'h00, stop: 1'b1, exp_vld: 1'b1, exp_err: 5'b00000};
        rx_tab[4] = '{data: 8'hFF, stop: 1'b0, exp_vld: 1'b0, exp_err: 5'b00010};
        rx_tab[5] = '{data: 8'h80, stop: 1'b1, exp_vld: 1'b1, exp_err: 5'b00000};

        do_reset();

        // TX waveform for 0xA5 with exact latency from the handshake edge.
        @(negedge clk);
        io_out_data = 8'hA5;
        io_out_vld  = 1'b1;
        @(posedge clk);
        #1 io_out_vld = 1'b0;
        @(negedge clk);
        check("tx_high_before_n1", uart_txd, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int off = 0; off < 10 * CPB; off++) begin
            @(negedge clk);
            check("tx_a5_wave", uart_txd, fr[off / CPB]);
        end

        // Back-to-back frames: start-to-start spacing.
        repeat (5) @(negedge clk);
        mon_q.delete();
        mon_t.delete();
        mon_en = 1'b1;
        cpu_write(8'h3C);
        cpu_write(8'hC3);
        wait_mon(2);
        if (mon_q.size() >= 2) begin
            check("tx_period", mon_t[1] - mon_t[0], 10 * CPB + 1);
            check("tx_b2b_byte0", mon_q[0], 8'h3C);
            check("tx_b2b_byte1", mon_q[1], 8'hC3);
        end

        // Randomized TX traffic against a FIFO-order queue.
        repeat (50) @(negedge clk);
        mon_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            cpu_write(b);
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_mon(10);
        for (int i = 0; i < 10 && i < mon_q.size(); i++)
            check("tx_rand_byte", mon_q[i], exp_q[i]);
        check("tx_frame_shape", mon_bad, 0);
        mon_en = 1'b0;

        // RX table: one frame per row from a clean reset.
        foreach (rx_tab[r]) begin
            do_reset();
            send_rx(rx_tab[r].data, rx_tab[r].stop);
            check("rx_tab_vld", io_in_vld, rx_tab[r].exp_vld);
            check("rx_tab_err", io_err, rx_tab[r].exp_err);
            if (rx_tab[r].exp_vld) begin
                check("rx_tab_data", io_in_data, rx_tab[r].data);
                cpu_pop(got);
                @(negedge clk);
                check("rx_tab_vld_after_pop", io_in_vld, 0);
            end
        end

        // Two-cycle glitch on an idle line is a false start.
        do_reset();
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("false_start_err", io_err, 5'b00100);
        check("false_start_vld", io_in_vld, 0);

        // Overrun: five frames while the CPU does not pop.
        do_reset();
        for (int i = 0; i < 5; i++) send_rx(8'h11 * (i + 1), 1'b1);
        check("overrun_err", io_err, 5'b00001);
        for (int i = 0; i < 4; i++) begin
            check("overrun_vld", io_in_vld, 1);
            cpu_pop(got);
            check("overrun_data", got, 8'h11 * (i + 1));
        end
        @(negedge clk);
        check("overrun_empty", io_in_vld, 0);

        // TX FIFO fills behind a busy transmitter, then reset mid-frame.
        do_reset();
        for (int i = 0; i < 5; i++) cpu_write(8'h60 + 8'(i));
        @(negedge clk);
        check("tx_full_rdy", io_out_rdy, 0);
        check("tx_midframe_low", uart_txd, 0);
        rst = 1'b1;
        #1;
        check("abort_txd", uart_txd, 1);
        check("abort_rdy", io_out_rdy, 0);
        check("abort_err", io_err, 0);
        check("abort_in_vld", io_in_vld, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rdy_rise", io_out_rdy, 1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        check("abort_tx_silent", lows, 0);

        // Randomized RX: bounded queue model with framing and overrun flags.
        do_reset();
        exp_q.delete();
        exp_err = 5'b00000;
        for (int i = 0; i < 16; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_rx(b, stop);
            if (!stop)                   exp_err[1] = 1'b1;
            else if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                         exp_err[0] = 1'b1;
            check("rx_rand_err", io_err, exp_err);
            check("rx_rand_vld", io_in_vld, exp_q.size() != 0);
            npop = $urandom_range(0, exp_q.size());
            for (int k = 0; k < npop; k++) begin
                cpu_pop(got);
                check("rx_rand_data", got, exp_q.pop_front());
            end
        end
        while (exp_q.size() != 0) begin
            check("rx_drain_vld", io_in_vld, 1);
            cpu_pop(got);
            check("rx_drain_data", got, exp_q.pop_front());
        end
        @(negedge clk);
        check("rx_drain_empty", io_in_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
